// File: rtl/button_filter.sv
// Push-button conditioner: two-flop synchronizer, per-button debounce FSM,
// sticky press flags, a shared press counter and a small read-only register
// window whose flag register clears on read.
module button_filter #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] button,
  input  logic [11:0]      addr,
  input  logic             rd_en,
  output logic [31:0]      rdata,
  output logic [N_BTN-1:0] btn_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [11:0] ADDR_LEVEL = 12'h000;
  localparam logic [11:0] ADDR_FLAG  = 12'h004;
  localparam logic [11:0] ADDR_COUNT = 12'h008;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE,
    S_HIGH,
    S_FALL
  } state_t;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  state_t           state_q [N_BTN];
  state_t           state_d [N_BTN];
  logic [CW-1:0]    cnt_q   [N_BTN];
  logic [CW-1:0]    cnt_d   [N_BTN];
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] flag_q, flag_d;
  logic [N_BTN-1:0] rise;
  logic [15:0]      count_q, count_d;
  logic             clr_rd;

  // Two-flop synchronizer on the raw pad levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM state, counters and stable levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= S_LOW;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
    end
  end

  // Per-button next state: a level is accepted after DEBOUNCE_CYCLES
  // consecutive samples; any opposite sample abandons the count
  always_comb begin
    level_d = level_q;
    rise    = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_LOW: begin
          if (sync2_q[i]) begin
            state_d[i] = S_RISE;
            cnt_d[i]   = CW'(1);
          end
        end
        S_RISE: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == TERM) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            rise[i]    = 1'b1;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        S_HIGH: begin
          if (!sync2_q[i]) begin
            state_d[i] = S_FALL;
            cnt_d[i]   = CW'(1);
          end
        end
        S_FALL: begin
          if (sync2_q[i]) begin
            state_d[i] = S_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == TERM) begin
            state_d[i] = S_LOW;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
          end else if (cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = S_LOW;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Sticky flags (a same-cycle rise beats a clearing read) and press count
  always_comb begin
    clr_rd  = rd_en && (addr == ADDR_FLAG);
    flag_d  = (clr_rd ? '0 : flag_q) | rise;
    count_d = count_q;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      count_d = count_d + 16'(rise[i]);
    end
  end

  // Press flag and press count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q  <= '0;
      count_q <= '0;
    end else begin
      flag_q  <= flag_d;
      count_q <= count_d;
    end
  end

  // Read mux from registered state only
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_LEVEL: rdata = 32'(level_q);
      ADDR_FLAG:  rdata = 32'(flag_q);
      ADDR_COUNT: rdata = {16'b0, count_q};
      default:    rdata = '0;
    endcase
  end

  assign btn_level = level_q;

endmodule

// File: doc/button_filter.md
BUTTON_FILTER -- requirements
Module: button_filter

Interface
REQ-001 The block SHALL have parameter N_BTN, default 5, meaning the number of push-button inputs.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 200000, meaning the number of consecutive clk cycles a level must hold before it is accepted; legal range 2..2^24.
REQ-003 The block SHALL have port clk, input, 1 bit, the board clock (same clock as the display driver).
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port button, input, N_BTN bits, the raw asynchronous pad levels (1 = pressed).
REQ-006 The block SHALL have port addr, input, 12 bits, the bus offset from the Bridge button window.
REQ-007 The block SHALL have port rd_en, input, 1 bit, a single-cycle bus read strobe.
REQ-008 The block SHALL have port rdata, output, 32 bits, the read data returned to the Bridge rdata_from_btn.
REQ-009 The block SHALL have port btn_level, output, N_BTN bits, the debounced button levels.

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer (sync1 then sync2) before any other logic.
REQ-011 Each button SHALL run an independent FSM with four states:
- S_LOW: stable 0.
- S_RISE: sync2=1 while counting.
- S_HIGH: stable 1.
- S_FALL: sync2=0 while counting.
REQ-012 S_LOW -> S_RISE on sync2=1; counter is loaded with 1.
REQ-013 In S_RISE, sync2=1 increments the counter; when the counter equals DEBOUNCE_CYCLES-1 and sync2=1, the FSM moves to S_HIGH and the stable level becomes 1.
REQ-014 In S_RISE, sync2=0 returns the FSM to S_LOW with counter 0 (glitch rejected).
REQ-015 S_HIGH, S_FALL and S_LOW SHALL be handled symmetrically to REQ-012..REQ-014 with polarities inverted.
REQ-016 Stable-level latency SHALL be exactly 2+DEBOUNCE_CYCLES clk edges from the first edge sampling the new raw level, provided the level holds continuously.
REQ-017 Any raw pulse shorter than DEBOUNCE_CYCLES cycles SHALL NOT change the stable level.
REQ-018 The counter width SHALL be clog2(DEBOUNCE_CYCLES); the counter SHALL saturate and never wrap.
REQ-019 The S_RISE -> S_HIGH transition SHALL set sticky press_flag[i].
REQ-020 A 16-bit press_count SHALL increment once per S_RISE -> S_HIGH transition on any button, and SHALL wrap 0xFFFF -> 0x0000.
REQ-021 When several buttons complete a rise in the same cycle, press_count SHALL increment by the number of such buttons.
REQ-022 rdata SHALL be combinational from registered state, zero-extended, as follows:
- 0x000: btn_level.
- 0x004: press_flag.
- 0x008: {16'b0, press_count}.
- Any other offset: 0.
REQ-023 When rd_en=1 and addr=0x004 at a clk edge, press_flag SHALL clear, with rdata that cycle showing the pre-clear value.
REQ-024 If a rise completes in the same cycle as a clearing read, that button's press_flag SHALL remain 1; the new event wins.
REQ-025 rd_en at any address other than 0x004 SHALL have no side effect.
REQ-026 btn_level SHALL equal the stable level of each FSM.

Reset
REQ-027 While rst=1, the following SHALL be held: sync flops 0, all FSMs in S_LOW, counters 0, press_flag 0, press_count 0, btn_level 0, rdata 0.
REQ-028 Reset asserted mid-count SHALL abandon the count, and a button held through reset release SHALL be re-qualified from S_LOW, producing a new press event after 2+DEBOUNCE_CYCLES cycles.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Scenario: button[0] 0->1 held -> btn_level[0]=1 exactly 6 edges later; press_flag=0x01; press_count=1.
REQ-030 Scenario: button[2] high for 3 cycles then low -> btn_level stays 0; press_count stays 0.
REQ-031 Scenario: read 0x004 with flags=0x05 -> rdata=0x00000005; next read returns 0.
REQ-032 Scenario: button[1] rise completes on the same edge as a 0x004 read -> after the edge, press_flag=0x02.
REQ-033 Scenario: buttons 0 and 4 rise together -> press_count increments by 2; 0x008 reads 0x00000002.
REQ-034 Scenario: rst pulsed while button[3] is held and stable -> btn_level=0 during reset; after release, btn_level[3]=1 six edges later and press_count=1.
